// File: rtl/pop_adc_pkg.sv
// Shared types and sizing helpers for the pop_adc conversion pipeline.
package pop_adc_pkg;

  localparam int POP_ADC_SAMPLE_W = 12;

  typedef logic [POP_ADC_SAMPLE_W-1:0] sample_t;

  // A block of 2^log2_decim samples never exceeds this many bits.
  function automatic int acc_width(input int sample_w, input int log2_decim);
    return sample_w + log2_decim;
  endfunction

  // Level must represent 0..depth inclusive.
  function automatic int fifo_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pop_adc_sync_fifo.sv
// Show-ahead synchronous FIFO with level output. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is ignored
// and the caller decides what a drop means.
module pop_adc_sync_fifo
  import pop_adc_pkg::*;
#(
  parameter int WIDTH = POP_ADC_SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                            clk_1Mhz,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            push,
  input  logic [WIDTH-1:0]                push_data,
  input  logic                            pop,
  output logic [WIDTH-1:0]                head_data,
  output logic                            empty,
  output logic                            full,
  output logic [fifo_level_w(DEPTH)-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = fifo_level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty     = (level == '0);
  assign full      = (level == LVL_W'(DEPTH));
  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & (~full | pop_ok);
  assign head_data = mem[rd_ptr];

  // Storage, pointers and level; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk_1Mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      level <= level + LVL_W'(1);
      else if (pop_ok && !push_ok) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/pop_adc_decimator.sv
// Boxcar decimator: averages blocks of 2^LOG2_DECIM ADC samples and queues
// the averages on a valid/ready stream. Results arriving while the queue is
// full are dropped and flagged on the sticky overflow output.
// Build option POP_ADC_DECIM_ROUND_EN: round-half-up with saturation instead
// of a truncating shift.
module pop_adc_decimator
  import pop_adc_pkg::*;
#(
  parameter int SAMPLE_W   = POP_ADC_SAMPLE_W,
  parameter int LOG2_DECIM = 2,
  parameter int DEPTH      = 4
) (
  input  logic                            clk_1Mhz,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            sample_valid,
  input  logic [SAMPLE_W-1:0]             sample_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SAMPLE_W-1:0]             out_data,
  output logic [fifo_level_w(DEPTH)-1:0]  fifo_level,
  output logic                            overflow
);

  localparam int ACC_W = acc_width(SAMPLE_W, LOG2_DECIM);
  localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_DECIM) - 1);

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [CNT_W-1:0]    count;
  logic [SAMPLE_W-1:0] result;
  logic                block_done;
  logic                fifo_empty;
  logic                fifo_full;
  logic                popping;

  assign sum        = acc + ACC_W'(sample_data);
  assign block_done = sample_valid & (count == CNT_LAST) & ~clear;
  assign out_valid  = ~fifo_empty;
  assign popping    = out_valid & out_ready;

`ifdef POP_ADC_DECIM_ROUND_EN
  if (LOG2_DECIM > 0) begin : g_round
    localparam int RND_W = ACC_W + 1;
    localparam logic [RND_W-1:0] HALF = RND_W'(1) << (LOG2_DECIM - 1);
    localparam logic [RND_W-1:0] MAX_CODE = {{(RND_W-SAMPLE_W){1'b0}}, {SAMPLE_W{1'b1}}};
    logic [RND_W-1:0] rounded;
    assign rounded = (RND_W'(sum) + HALF) >> LOG2_DECIM;
    assign result  = (rounded > MAX_CODE) ? {SAMPLE_W{1'b1}} : rounded[SAMPLE_W-1:0];
  end else begin : g_pass
    assign result = sum[SAMPLE_W-1:0];
  end
`else
  logic [ACC_W-1:0] shifted;
  assign shifted = sum >> LOG2_DECIM;
  assign result  = shifted[SAMPLE_W-1:0];
`endif

  // Accumulate the current block; restart on the last sample whether or not the push lands.
  always_ff @(posedge clk_1Mhz or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (sample_valid) begin
      if (count == CNT_LAST) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= sum;
        count <= count + CNT_W'(1);
      end
    end
  end

  // Sticky drop flag: a finished block met a full queue with no pop to make room.
  always_ff @(posedge clk_1Mhz or posedge reset) begin
    if (reset)                                      overflow <= 1'b0;
    else if (clear)                                 overflow <= 1'b0;
    else if (block_done && fifo_full && !popping)   overflow <= 1'b1;
  end

  pop_adc_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_1Mhz  (clk_1Mhz),
    .reset     (reset),
    .clear     (clear),
    .push      (block_done),
    .push_data (result),
    .pop       (out_ready),
    .head_data (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_pop_adc_decimator.sv
`timescale 1ns/1ps
module tb_pop_adc_decimator;
  import pop_adc_pkg::*;

  localparam int SAMPLE_W   = 12;
  localparam int LOG2_DECIM = 2;
  localparam int DEPTH      = 4;
  localparam int LVL_W      = $clog2(DEPTH) + 1;

  logic                clk_1Mhz = 1'b0;
  logic                reset;
  logic                clear;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_data;
  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_data;
  logic [LVL_W-1:0]    fifo_level;
  logic                overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #500 clk_1Mhz = ~clk_1Mhz;

  pop_adc_decimator #(
    .SAMPLE_W   (SAMPLE_W),
    .LOG2_DECIM (LOG2_DECIM),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_1Mhz     (clk_1Mhz),
    .reset        (reset),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  // One strobe on a single clock edge; returns at the negedge after that edge.
  task automatic strobe(input logic [SAMPLE_W-1:0] d);
    @(negedge clk_1Mhz);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk_1Mhz);
    sample_valid = 1'b0;
  endtask

  task automatic feed_block(input logic [SAMPLE_W-1:0] d);
    for (int i = 0; i < 4; i++) strobe(d);
  endtask

  task automatic pulse_clear();
    @(negedge clk_1Mhz);
    clear = 1'b1;
    @(negedge clk_1Mhz);
    clear = 1'b0;
  endtask

  logic [SAMPLE_W-1:0] exp_sum6;

  initial begin
    reset        = 1'b1;
    clear        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    out_ready    = 1'b0;
`ifdef POP_ADC_DECIM_ROUND_EN
    exp_sum6 = 12'd2;
`else
    exp_sum6 = 12'd1;
`endif

    // Reset state
    @(negedge clk_1Mhz);
    @(negedge clk_1Mhz);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Basic average with the consumer always ready
    out_ready = 1'b1;
    strobe(12'd100);
    strobe(12'd200);
    strobe(12'd300);
    check_eq("basic_not_yet", 32'(out_valid), 32'd0);
    strobe(12'd400);
    check_eq("basic_valid", 32'(out_valid), 32'd1);
    check_eq("basic_data", 32'(out_data), 32'd250);
    check_eq("basic_level1", 32'(fifo_level), 32'd1);
    @(negedge clk_1Mhz);
    check_eq("basic_valid_drop", 32'(out_valid), 32'd0);
    check_eq("basic_level0", 32'(fifo_level), 32'd0);

    // Truncate vs round
    strobe(12'd1); strobe(12'd1); strobe(12'd1); strobe(12'd2);
    check_eq("sum5", 32'(out_data), 32'd1);
    strobe(12'd1); strobe(12'd1); strobe(12'd2); strobe(12'd2);
    check_eq("sum6", 32'(out_data), 32'(exp_sum6));
    feed_block(12'd4095);
    check_eq("full_scale", 32'(out_data), 32'd4095);
    check_eq("full_scale_valid", 32'(out_valid), 32'd1);

    // Full queue and overflow: five results, only four fit
    @(negedge clk_1Mhz);
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) feed_block(SAMPLE_W'(16 * k));
    check_eq("ovf_level", 32'(fifo_level), 32'd4);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq("ovf_drain_valid", 32'(out_valid), 32'd1);
      check_eq("ovf_drain_data", 32'(out_data), 32'(16 * k));
      @(negedge clk_1Mhz);
    end
    check_eq("ovf_drain_empty", 32'(out_valid), 32'd0);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);
    out_ready = 1'b0;
    pulse_clear();
    check_eq("ovf_cleared", 32'(overflow), 32'd0);

    // Push and pop together while full
    for (int k = 1; k <= 4; k++) feed_block(SAMPLE_W'(16 * k));
    check_eq("pp_level_full", 32'(fifo_level), 32'd4);
    strobe(12'd80); strobe(12'd80); strobe(12'd80);
    @(negedge clk_1Mhz);
    sample_valid = 1'b1;
    sample_data  = 12'd80;
    out_ready    = 1'b1;
    @(negedge clk_1Mhz);
    sample_valid = 1'b0;
    out_ready    = 1'b0;
    check_eq("pp_level", 32'(fifo_level), 32'd4);
    check_eq("pp_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check_eq("pp_order", 32'(out_data), 32'(16 * k));
      @(negedge clk_1Mhz);
    end
    check_eq("pp_empty", 32'(fifo_level), 32'd0);

    // Clear mid-block, with a queued result and a sample presented alongside clear
    out_ready = 1'b0;
    feed_block(12'd500);
    check_eq("clr_pre_level", 32'(fifo_level), 32'd1);
    strobe(12'd1000);
    strobe(12'd1000);
    @(negedge clk_1Mhz);
    clear        = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 12'd4000;
    @(negedge clk_1Mhz);
    clear        = 1'b0;
    sample_valid = 1'b0;
    check_eq("clr_level", 32'(fifo_level), 32'd0);
    check_eq("clr_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    strobe(12'd8); strobe(12'd8); strobe(12'd8);
    check_eq("clr_no_early", 32'(out_valid), 32'd0);
    strobe(12'd8);
    check_eq("clr_result_valid", 32'(out_valid), 32'd1);
    check_eq("clr_result", 32'(out_data), 32'd8);
    @(negedge clk_1Mhz);

    // Asynchronous reset mid-block
    out_ready = 1'b0;
    feed_block(12'd200);
    check_eq("arst_pre_data", 32'(out_data), 32'd200);
    strobe(12'd1000); strobe(12'd1000); strobe(12'd1000);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_data", 32'(out_data), 32'd0);
    check_eq("arst_level", 32'(fifo_level), 32'd0);
    @(negedge clk_1Mhz);
    reset     = 1'b0;
    out_ready = 1'b1;
    strobe(12'd40); strobe(12'd40); strobe(12'd40);
    check_eq("arst_no_early", 32'(out_valid), 32'd0);
    strobe(12'd40);
    check_eq("arst_result_valid", 32'(out_valid), 32'd1);
    check_eq("arst_result", 32'(out_data), 32'd40);
    @(negedge clk_1Mhz);
    check_eq("arst_drained", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
